// File: rtl/alu_operand_loader.sv
// Sequential operand loader for the 4-bit ALU board: debounced single key captures A, B, opcode,
// strobes op_valid for one cycle and latches the ALU result. Optional build macro: RESULT_CHAIN_EN.
module alu_operand_loader #(
  parameter int BIT        = 4,
  parameter int OPCODE     = 4,
  parameter int DEB_CYCLES = 250000
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic [BIT-1:0]    din,
  input  logic              key_n,
  input  logic [BIT-1:0]    c,
  input  logic              flag,
  output logic [BIT-1:0]    a,
  output logic [BIT-1:0]    b,
  output logic [OPCODE-1:0] op,
  output logic              op_valid,
  output logic [BIT-1:0]    res,
  output logic              res_flag,
  output logic [2:0]        state
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_e;

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press;

  state_e      state_q, state_next;
  logic        load_a, load_b, load_op, load_res, a_from_res;
  logic [BIT-1:0]    a_q, b_q, res_q;
  logic [OPCODE-1:0] op_q;
  logic        res_flag_q, op_valid_q;

  // Key path: two-flop synchronizer, then a level that only moves after the
  // synchronized key has disagreed with it for DEB_CYCLES consecutive cycles.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      deb_q      <= 1'b1;
      deb_prev_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // which is what makes sync1 -> sync2 a real two-stage shift.
      sync1_q    <= key_n;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        deb_q <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Falling edge of the debounced level only; release is silent.
  assign press = deb_prev_q & ~deb_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_next = state_q;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    load_res   = 1'b0;
    a_from_res = 1'b0;
    case (state_q)
      S_A: if (press) begin
        load_a     = 1'b1;
        state_next = S_B;
      end
      S_B: if (press) begin
        load_b     = 1'b1;
        state_next = S_OP;
      end
      S_OP: if (press) begin
        load_op    = 1'b1;
        state_next = S_EXEC;
      end
      // Single-cycle state: a press landing here is deliberately dropped.
      S_EXEC: begin
        load_res   = 1'b1;
        state_next = S_SHOW;
      end
      S_SHOW: if (press) begin
`ifdef RESULT_CHAIN_EN
        load_a     = 1'b1;
        a_from_res = 1'b1;
        state_next = S_B;
`else
        state_next = S_A;
`endif
      end
      default: state_next = S_A;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q    <= S_A;
      op_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_q      <= '0;
      res_flag_q <= 1'b0;
    end else begin
      state_q    <= state_next;
      op_valid_q <= (state_next == S_EXEC);
      if (load_a)   a_q  <= a_from_res ? res_q : din;
      if (load_b)   b_q  <= din;
      if (load_op)  op_q <= din[OPCODE-1:0];
      if (load_res) begin
        res_q      <= c;
        res_flag_q <= flag;
      end
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign op       = op_q;
  assign op_valid = op_valid_q;
  assign res      = res_q;
  assign res_flag = res_flag_q;
  assign state    = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: directed debounce/latency cases plus randomized
// press/glitch sequences scored against a transaction-level model of the operand entry flow.
module tb_alu_operand_loader;

  localparam int BIT    = 4;
  localparam int OPCODE = 4;
  localparam int DEB    = 4;

  logic              CLOCK_50 = 1'b0;
  logic              rst = 1'b1;
  logic [BIT-1:0]    din = '0;
  logic              key_n = 1'b1;
  logic [BIT-1:0]    c;
  logic              flag;
  logic [BIT-1:0]    a, b, res;
  logic [OPCODE-1:0] op;
  logic              op_valid, res_flag;
  logic [2:0]        state;

  int tests = 0;
  int failures = 0;

  // Model of the operand-entry flow, advanced once per recognised press.
  int m_a, m_b, m_op, m_res, m_flag, m_state;
  int exp_pulses = 0;
  int seen_pulses = 0;
  int bad_valid = 0;
  bit mon_en = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  // Stand-in ALU: op 1 adds (flag = carry), op 2 subtracts (flag = borrow), others xor (flag = zero).
  function automatic logic [BIT:0] alu(input int x, input int y, input int o);
    int r;
    case (o)
      1:       r = x + y;
      2:       r = (x - y) & 'h1f;
      default: r = ((x ^ y) == 0) ? 'h10 : (x ^ y);
    endcase
    return r[BIT:0];
  endfunction

  assign {flag, c} = alu(int'(a), int'(b), int'(op));

  alu_operand_loader #(.BIT(BIT), .OPCODE(OPCODE), .DEB_CYCLES(DEB)) dut (
    .CLOCK_50(CLOCK_50), .rst(rst), .din(din), .key_n(key_n), .c(c), .flag(flag),
    .a(a), .b(b), .op(op), .op_valid(op_valid), .res(res), .res_flag(res_flag), .state(state)
  );

  // op_valid must be high exactly while the FSM shows state 3, and never in reset.
  always @(negedge CLOCK_50) begin
    if (mon_en) begin
      if (op_valid) seen_pulses++;
      if (rst && op_valid) bad_valid++;
      if (!rst && (op_valid != (state == 3'd3))) bad_valid++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flag = 0; m_state = 0;
  endtask

  task automatic model_press(input int d);
    logic [BIT:0] r;
    case (m_state)
      0: begin m_a = d; m_state = 1; end
      1: begin m_b = d; m_state = 2; end
      2: begin
        m_op = d % (1 << OPCODE);
        r = alu(m_a, m_b, m_op);
        m_res = int'(r[BIT-1:0]);
        m_flag = int'(r[BIT]);
        m_state = 4;
        exp_pulses++;
      end
      default: begin
`ifdef RESULT_CHAIN_EN
        m_a = m_res; m_state = 1;
`else
        m_state = 0;
`endif
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".a"}, int'(a), m_a);
    check({tag, ".b"}, int'(b), m_b);
    check({tag, ".op"}, int'(op), m_op);
    check({tag, ".res"}, int'(res), m_res);
    check({tag, ".res_flag"}, int'(res_flag), m_flag);
    check({tag, ".state"}, int'(state), m_state);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge CLOCK_50);
    rst = 1'b1;
    repeat (cycles) @(negedge CLOCK_50);
    rst = 1'b0;
    model_reset();
  endtask

  // A clean physical press: held long enough to debounce, din scrambled after capture.
  task automatic do_press(input int d, input int hold);
    @(negedge CLOCK_50);
    din = BIT'(d);
    key_n = 1'b0;
    repeat (hold) @(negedge CLOCK_50);
    din = BIT'($urandom);
    key_n = 1'b1;
    repeat (DEB + 4) @(negedge CLOCK_50);
    model_press(d);
  endtask

  task automatic do_glitch(input int len);
    @(negedge CLOCK_50);
    din = BIT'($urandom);
    key_n = 1'b0;
    repeat (len) @(negedge CLOCK_50);
    key_n = 1'b1;
    repeat (DEB + 2) @(negedge CLOCK_50);
  endtask

  initial begin
    model_reset();
    do_reset(2);
    mon_en = 1'b1;
    check("reset.op_valid", int'(op_valid), 0);
    check_all("reset");

    // A 3-cycle low is one short of the debounce window.
    do_glitch(DEB - 1);
    check_all("glitch");

    // Latency: first sampling edge is edge 0, capture lands on edge DEB+2.
    @(negedge CLOCK_50);
    din = 4'd3;
    key_n = 1'b0;
    @(posedge CLOCK_50);
    repeat (DEB + 1) @(posedge CLOCK_50);
    #1 check("latency.early_state", int'(state), 0);
    @(posedge CLOCK_50);
    #1 check("latency.state", int'(state), 1);
    check("latency.a", int'(a), 3);
    // Still held with a new din: no second capture.
    din = 4'd12;
    repeat (DEB + 4) @(negedge CLOCK_50);
    check("held.state", int'(state), 1);
    key_n = 1'b1;
    repeat (DEB + 4) @(negedge CLOCK_50);
    model_press(3);

    do_press(5, DEB + 4);
    do_press(1, DEB + 4);
    check_all("seq");
    check("seq.res_value", int'(res), 8);
    check("seq.pulses", seen_pulses, 1);

    do_press(9, DEB + 4);
    check_all("show_press");
`ifdef RESULT_CHAIN_EN
    check("show_press.a_chain", int'(a), 8);
`else
    check("show_press.a_kept", int'(a), 3);
`endif

    // Reset in the middle of entry, then a capture must land in A again.
    do_reset(1);
    do_press(6, DEB + 4);
    do_press(10, DEB + 4);
    check("mid.state_before", int'(state), 2);
    do_reset(1);
    check_all("mid_reset");
    do_press(7, DEB + 4);
    check_all("after_mid_reset");

    // Key held low right through S_EXEC and into S_SHOW yields one press only.
    do_press(2, DEB + 4);
    do_press(1, 3 * DEB + 20);
    check_all("long_hold");

    // Randomized presses, holds and glitches.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) do_glitch($urandom_range(1, DEB - 1));
      do_press($urandom_range(0, (1 << BIT) - 1), $urandom_range(DEB + 3, DEB + 12));
      check_all($sformatf("rand%0d", i));
    end

    check("op_valid.pulses", seen_pulses, exp_pulses);
    check("op_valid.decode", bad_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
